// File: rtl/sa_feed_sequencer.sv
// ---------------------------------------------------------------------------
// sa_feed_sequencer
//
// Sequences one matrix-multiply job into a HPE x VPE systolic array:
//    - clears the array accumulators for one cycle,
//    - accepts K_LEN operand beats (A column vector + B row vector),
//    - skews every lane diagonally so lane i / j reaches the array i / j
//      cycles after lane 0,
//    - waits for the wavefront plus the PE pipeline to drain,
//    - pulses DONE when the array results are final.
//
// Ports
//    CLK       in   clock, rising edge
//    RST       in   asynchronous active-low reset
//    START     in   job request, sampled only in IDLE
//    K_LEN     in   operand beat count, latched on an accepted START
//    OP_VALID  in   operand beat present on A_IN / B_IN
//    OP_READY  out  beat accepted this cycle when OP_VALID is also high
//    A_IN      in   A column vector, lane i at [(i+1)*WIDTH-1 : i*WIDTH]
//    B_IN      in   B row vector, same lane packing
//    AA        out  skewed A bus to the array
//    BB        out  skewed B bus to the array
//    SA_RST    out  registered active-low accumulator clear to the array
//    BUSY      out  high in every state except IDLE
//    DONE      out  one-cycle pulse, array results final
// ---------------------------------------------------------------------------

// Per-lane delay line: DEPTH register stages, all cleared by reset.
module sa_skew_line #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < DEPTH; s++) begin
            stage[s] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int s = 1; s < DEPTH; s++) begin
            stage[s] <= stage[s-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for START with a non-zero K_LEN
// CLEAR  | one cycle with SA_RST low, beat counter cleared
// FEED   | OP_READY high, accepting beats until K_LEN have been taken
// DRAIN  | DRAIN_CYC cycles for the skewed wavefront and PE pipeline
// FIN    | DONE pulse, then back to IDLE
module sa_feed_sequencer #(
   parameter int WIDTH = 16,
   parameter int HPE   = 8,
   parameter int VPE   = 8,
   parameter int KW    = 16,
   parameter int PIPE  = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [KW-1:0]        K_LEN,
   input  logic                 OP_VALID,
   output logic                 OP_READY,
   input  logic [WIDTH*HPE-1:0] A_IN,
   input  logic [WIDTH*VPE-1:0] B_IN,
   output logic [WIDTH*HPE-1:0] AA,
   output logic [WIDTH*VPE-1:0] BB,
   output logic                 SA_RST,
   output logic                 BUSY,
   output logic                 DONE
);

   // Last operand enters lane 0 one cycle after acceptance, reaches the far
   // corner PE HPE+VPE-2 cycles later, then needs PIPE cycles to accumulate.
   localparam int DRAIN_CYC = HPE + VPE - 2 + PIPE;
   localparam int DCW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [KW-1:0]  k_len_q;
   logic [KW-1:0]  beat_cnt;
   logic [DCW-1:0] drain_cnt;
   logic           start_ok;
   logic           accept;
   logic           last_beat;
   logic           drain_end;
   logic           sa_rst_q;

   assign start_ok  = START && (K_LEN != '0);
   assign accept    = OP_VALID && OP_READY;
   // Compare against K_LEN-1 so a full-scale K_LEN never needs the counter
   // to reach 2**KW.
   assign last_beat = accept && (beat_cnt == (k_len_q - KW'(1)));
   assign drain_end = (drain_cnt == DRAIN_LAST);

   // ---------------- state register ----------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start_ok)  state_nxt = S_CLEAR;
         S_CLEAR:                state_nxt = S_FEED;
         S_FEED:  if (last_beat) state_nxt = S_DRAIN;
         S_DRAIN: if (drain_end) state_nxt = S_FIN;
         S_FIN:                  state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      OP_READY = 1'b0;
      BUSY     = 1'b1;
      DONE     = 1'b0;
      unique case (state)
         S_IDLE:  BUSY     = 1'b0;
         S_FEED:  OP_READY = 1'b1;
         S_FIN:   DONE     = 1'b1;
         default: ;
      endcase
   end

   // Registered from next state so SA_RST is low for exactly the CLEAR
   // cycle and low during reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sa_rst_q <= 1'b0;
      end else begin
         sa_rst_q <= (state_nxt != S_CLEAR);
      end
   end

   assign SA_RST = sa_rst_q;

   // ---------------- job length and counters ----------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         k_len_q <= '0;
      end else if ((state == S_IDLE) && start_ok) begin
         k_len_q <= K_LEN;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         beat_cnt <= '0;
      end else if (state == S_CLEAR) begin
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + KW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         drain_cnt <= '0;
      end else if (state != S_DRAIN) begin
         drain_cnt <= '0;
      end else if (!drain_end) begin
         drain_cnt <= drain_cnt + DCW'(1);
      end
   end

   // ---------------- skew lines ----------------
   // Zeros are shifted in whenever no beat is accepted; zero operands leave
   // the accumulators untouched, so bubbles need no stall.
   for (genvar i = 0; i < HPE; i++) begin : g_a_lane
      sa_skew_line #(
         .WIDTH (WIDTH),
         .DEPTH (i + 1)
      ) u_skew (
         .clk   (CLK),
         .rst_n (RST),
         .din   (accept ? A_IN[i*WIDTH +: WIDTH] : '0),
         .dout  (AA[i*WIDTH +: WIDTH])
      );
   end

   for (genvar j = 0; j < VPE; j++) begin : g_b_lane
      sa_skew_line #(
         .WIDTH (WIDTH),
         .DEPTH (j + 1)
      ) u_skew (
         .clk   (CLK),
         .rst_n (RST),
         .din   (accept ? B_IN[j*WIDTH +: WIDTH] : '0),
         .dout  (BB[j*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_sa_feed_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sa_feed_sequencer
//
// Drives jobs cycle by cycle. The driver sets the expected control outputs
// for each cycle; a reference delay-line history built from the beats the
// bench expects to be accepted gives the expected AA/BB; the expected DONE
// cycle of every job is queued at the START edge and popped when DONE rises.
// ---------------------------------------------------------------------------
module tb_sa_feed_sequencer;

   localparam int W    = 16;
   localparam int H    = 8;
   localparam int V    = 8;
   localparam int KW   = 16;
   localparam int DRN  = H + V - 2 + 1;

   logic            CLK;
   logic            RST;
   logic            START;
   logic [KW-1:0]   K_LEN;
   logic            OP_VALID;
   logic            OP_READY;
   logic [W*H-1:0]  A_IN;
   logic [W*V-1:0]  B_IN;
   logic [W*H-1:0]  AA;
   logic [W*V-1:0]  BB;
   logic            SA_RST;
   logic            BUSY;
   logic            DONE;

   sa_feed_sequencer #(
      .WIDTH (W),
      .HPE   (H),
      .VPE   (V),
      .KW    (KW),
      .PIPE  (1)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .K_LEN    (K_LEN),
      .OP_VALID (OP_VALID),
      .OP_READY (OP_READY),
      .A_IN     (A_IN),
      .B_IN     (B_IN),
      .AA       (AA),
      .BB       (BB),
      .SA_RST   (SA_RST),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   bit exp_ready  = 1'b0;
   bit exp_busy   = 1'b0;
   bit exp_sa_rst = 1'b0;

   logic [W*H-1:0] hist_a [$];
   logic [W*V-1:0] hist_b [$];
   int             done_q [$];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   // Reference skew history: newest entry at index 0.
   always @(posedge CLK) begin
      cyc = cyc + 1;
      if (!RST) begin
         hist_a.delete();
         hist_b.delete();
      end else begin
         hist_a.push_front((exp_ready && OP_VALID) ? A_IN : '0);
         hist_b.push_front((exp_ready && OP_VALID) ? B_IN : '0);
         if (hist_a.size() > H) void'(hist_a.pop_back());
         if (hist_b.size() > V) void'(hist_b.pop_back());
      end
   end

   always @(negedge CLK) begin
      logic [W*H-1:0] exp_aa;
      logic [W*V-1:0] exp_bb;
      logic [W*H-1:0] ta;
      logic [W*V-1:0] tb;
      exp_aa = '0;
      exp_bb = '0;
      if (RST) begin
         for (int i = 0; i < H; i++) begin
            if (hist_a.size() > i) begin
               ta = hist_a[i];
               exp_aa[i*W +: W] = ta[i*W +: W];
            end
         end
         for (int j = 0; j < V; j++) begin
            if (hist_b.size() > j) begin
               tb = hist_b[j];
               exp_bb[j*W +: W] = tb[j*W +: W];
            end
         end
      end
      chk("aa", AA, exp_aa);
      chk("bb", BB, exp_bb);
      chk("op_ready", OP_READY, exp_ready);
      chk("busy", BUSY, exp_busy);
      chk("sa_rst", SA_RST, exp_sa_rst);
      if (DONE) begin
         if (done_q.size() == 0) chk("done_unexp", 1, 0);
         else                    chk("done_cyc", cyc, done_q.pop_front());
      end
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_ops();
      A_IN = {$urandom, $urandom, $urandom, $urandom};
      B_IN = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // One job: bubbles cover feed cycles [bub_at, bub_at+bub_len); poke
   // raises START with K_LEN=9 during DRAIN, which must be ignored.
   task automatic run_job(input int k, input int bub_at, input int bub_len, input bit poke);
      int beats;
      int r;
      START = 1'b1;
      K_LEN = KW'(k);
      OP_VALID = 1'b1;
      rand_ops();
      next_cycle();                       // START sampling edge; cycle 1 = CLEAR
      done_q.push_back(cyc + k + DRN + 1 + bub_len);
      START = 1'b0;
      K_LEN = KW'(k + 5);                 // must not affect the latched length
      exp_busy = 1'b1;
      exp_sa_rst = 1'b0;
      rand_ops();
      next_cycle();
      exp_sa_rst = 1'b1;
      exp_ready = 1'b1;
      beats = 0;
      r = 0;
      while (beats < k) begin
         OP_VALID = !(r >= bub_at && r < bub_at + bub_len);
         rand_ops();
         if (OP_VALID) beats++;
         r++;
         next_cycle();
      end
      exp_ready = 1'b0;
      for (int d = 0; d < DRN; d++) begin
         OP_VALID = 1'($urandom_range(0, 1));
         rand_ops();
         START = poke && (d >= 3) && (d < 10);
         K_LEN = 16'd9;
         next_cycle();
      end
      START = 1'b0;
      OP_VALID = 1'b0;
      next_cycle();                       // FIN
      exp_busy = 1'b0;
      next_cycle();                       // IDLE
      chk("done_pend", done_q.size(), 0);
      done_q.delete();
   endtask

   initial begin
      RST = 1'b0;
      START = 1'b0;
      K_LEN = '0;
      OP_VALID = 1'b0;
      A_IN = '0;
      B_IN = '0;
      #1;
      chk("rst_aa", AA, 0);
      chk("rst_bb", BB, 0);
      chk("rst_sa_rst", SA_RST, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_ready", OP_READY, 0);
      chk("rst_done", DONE, 0);
      repeat (3) next_cycle();
      RST = 1'b1;
      next_cycle();
      exp_sa_rst = 1'b1;
      next_cycle();

      // basic job, lane 0 of the first beat fixed at 3
      START = 1'b1;
      K_LEN = 16'd4;
      run_job(4, 100, 0, 1'b0);

      // bubbles mid-FEED
      run_job(3, 1, 2, 1'b0);

      // zero length: no job, no DONE
      START = 1'b1;
      K_LEN = 16'd0;
      OP_VALID = 1'b1;
      rand_ops();
      next_cycle();
      START = 1'b0;
      OP_VALID = 1'b0;
      repeat (30) next_cycle();

      // START while busy, then a normal job from IDLE
      run_job(5, 100, 0, 1'b1);
      run_job(2, 100, 0, 1'b0);

      // reset mid-FEED after beat 2 of K_LEN=8
      START = 1'b1;
      K_LEN = 16'd8;
      OP_VALID = 1'b1;
      rand_ops();
      next_cycle();
      START = 1'b0;
      exp_busy = 1'b1;
      exp_sa_rst = 1'b0;
      next_cycle();
      exp_ready = 1'b1;
      exp_sa_rst = 1'b1;
      rand_ops();
      next_cycle();
      rand_ops();
      next_cycle();
      RST = 1'b0;
      exp_ready = 1'b0;
      exp_busy = 1'b0;
      exp_sa_rst = 1'b0;
      #1;
      chk("abort_aa", AA, 0);
      chk("abort_bb", BB, 0);
      chk("abort_sa_rst", SA_RST, 0);
      chk("abort_busy", BUSY, 0);
      chk("abort_ready", OP_READY, 0);
      chk("abort_done", DONE, 0);
      OP_VALID = 1'b0;
      repeat (2) next_cycle();
      RST = 1'b1;
      next_cycle();
      exp_sa_rst = 1'b1;
      next_cycle();
      run_job(6, 2, 3, 1'b0);
      run_job(5, 0, 1, 1'b0);

      // full-scale length
      run_job(65535, 100, 0, 1'b0);

      repeat (10) next_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Pin lane 0 of the first accepted beat of the first job to 0x0003.
   initial begin
      @(posedge RST);
      wait (exp_ready == 1'b1);
      A_IN[W-1:0] = 16'h0003;
   end

endmodule
